// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a 16-bit enable/clear counter: prescaled enable,
// clears at start/terminal/CLEAR, terminal compare with one-shot or auto-reload.
module counter_seq_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        START,
  input  logic        STOP,
  input  logic        CLEAR,
  input  logic        MODE,
  input  logic [15:0] TERM,
  input  logic [15:0] CNT_VAL,
  output logic        CNT_EN,
  output logic        CNT_RESN,
  output logic        DONE,
  output logic        BUSY,
  output logic [1:0]  STATE,
  output logic [7:0]  WRAPS
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FIN   = 2'd3
  } seqState_t;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  seqState_t   state_r;
  logic [15:0] pre_r;
  logic [15:0] termQ_r;
  logic        modeQ_r;
  logic        done_r;
  logic [7:0]  wraps_r;

  logic        startCmd_s;
  logic        tick_s;
  logic        terminal_s;

  // Command arbitration and tick/terminal detection; a STOP cycle never ticks
  always_comb begin
    startCmd_s = START && !STOP && !CLEAR;
    tick_s     = (state_r == RUN) && !CLEAR && !STOP && (pre_r == PRE_LAST);
    terminal_s = tick_s && (CNT_VAL == termQ_r);
  end

  // Counter enable/clear decode; clear always wins and forces the enable low
  always_comb begin
    CNT_EN   = 1'b0;
    CNT_RESN = 1'b1;
    if (CLEAR) begin
      CNT_RESN = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          CNT_RESN = 1'b0;
        end
        RUN: begin
          if (terminal_s) begin
            CNT_RESN = !modeQ_r;
          end else begin
            CNT_EN = tick_s;
          end
        end
        PAUSE: begin
          CNT_RESN = 1'b1;
        end
        FIN: begin
          // A restart from FIN clears the counter in the START cycle itself
          CNT_RESN = !startCmd_s;
        end
        default: begin
          CNT_RESN = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, prescaler, latched terminal/mode, DONE pulse and wrap count
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r <= IDLE;
      pre_r   <= 16'd0;
      termQ_r <= 16'd0;
      modeQ_r <= 1'b0;
      done_r  <= 1'b0;
      wraps_r <= 8'd0;
    end else if (CLEAR) begin
      state_r <= IDLE;
      pre_r   <= 16'd0;
      done_r  <= 1'b0;
      wraps_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE, FIN: begin
          done_r <= 1'b0;
          if (startCmd_s) begin
            state_r <= RUN;
            termQ_r <= TERM;
            modeQ_r <= MODE;
            pre_r   <= 16'd0;
            wraps_r <= 8'd0;
          end
        end
        RUN: begin
          if (STOP) begin
            state_r <= PAUSE;
            done_r  <= 1'b0;
          end else begin
            pre_r  <= (pre_r == PRE_LAST) ? 16'd0 : pre_r + 16'd1;
            done_r <= terminal_s;
            if (terminal_s) begin
              if (modeQ_r) begin
                wraps_r <= (wraps_r == 8'hFF) ? 8'hFF : wraps_r + 8'd1;
              end else begin
                state_r <= FIN;
              end
            end
          end
        end
        PAUSE: begin
          done_r <= 1'b0;
          if (startCmd_s) begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          pre_r   <= 16'd0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign DONE  = done_r;
  assign WRAPS = wraps_r;
  assign STATE = state_r;
  assign BUSY  = (state_r == RUN) || (state_r == PAUSE);

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller for the 16-bit enable/clear counter datapath (`countVal`, `EN`, `RESN` style). It generates the counter's enable from a prescaler and clears the counter at start, at terminal count and on CLEAR. It compares the counter value against a latched terminal value and reports completion in one-shot or auto-reload mode. It sits between the control/switch logic and one counter instance, and is the only driver of that counter's EN and RESN.

## Interface
- PRESCALE, 4: clock cycles per counter increment; legal 1..65535. 1 means every cycle.
- CLK  input  1  rising-edge clock
- RES  input  1  asynchronous reset, active-high
- START  input  1  level sampled each cycle; start from IDLE/DONE, resume from PAUSE
- STOP  input  1  pause a running sequence
- CLEAR  input  1  abort to IDLE and zero the counter
- MODE  input  1  0 = one-shot, 1 = auto-reload; latched with TERM
- TERM  input  16  terminal count; latched on a fresh start
- CNT_VAL  input  16  current counter output, fed back from the counter
- CNT_EN  output  1  counter enable; combinational decode
- CNT_RESN  output  1  counter synchronous clear, active-low; combinational decode
- DONE  output  1  one-cycle registered pulse per terminal event
- BUSY  output  1  high in RUN or PAUSE
- STATE  output  2  IDLE=0, RUN=1, PAUSE=2, FIN=3
- WRAPS  output  8  auto-reload terminal events since start, saturating at 255

## Operation
- Registers:
  - state
  - prescaler `pre` (16 bit, counts 0..PRESCALE-1)
  - `term_q`, `mode_q`
  - DONE
  - WRAPS
- tick = (state==RUN) && (pre==PRESCALE-1).
- terminal = tick && (CNT_VAL==term_q).
- Command precedence each cycle: CLEAR > STOP > START.
- IDLE:
  - CNT_RESN=0, CNT_EN=0.
  - START -> RUN; latch TERM/MODE; pre=0; WRAPS=0.
- RUN:
  - pre increments and wraps to 0 on tick.
  - Non-terminal tick: CNT_EN=1.
  - terminal with mode_q=0: CNT_EN=0; -> FIN; DONE=1 next cycle.
  - terminal with mode_q=1: CNT_EN=0, CNT_RESN=0 (counter to 0); stay RUN; DONE=1 next cycle; WRAPS+1, saturating.
  - STOP -> PAUSE. The STOP cycle gives no tick effect: CNT_EN=0, and pre holds.
- PAUSE:
  - CNT_EN=0, CNT_RESN=1. pre and counter hold.
  - START -> RUN, resuming from the held pre. TERM/MODE are not re-latched.
- FIN:
  - CNT_EN=0, CNT_RESN=1; counter holds term_q.
  - START behaves as from IDLE: CNT_RESN=0 in that cycle, re-latch, -> RUN.
- CLEAR, any state: CNT_RESN=0, CNT_EN=0 that cycle; -> IDLE; pre=0; WRAPS=0; DONE=0 next cycle.
- In IDLE/FIN, the START cycle drives CNT_RESN=0, so the first RUN cycle sees CNT_VAL=0.
- TERM changes while RUN/PAUSE are ignored.
- TERM=0: the first tick is terminal.
- Comparison is exact 16-bit equality. No wrap past 0xFFFF occurs, because the counter is cleared or stopped at term_q.

## Timing
- Reset (RES high, asynchronous): state=IDLE, pre=0, term_q=0, mode_q=0, DONE=0, WRAPS=0. Hence CNT_EN=0, CNT_RESN=0, BUSY=0, STATE=0.
- Reset deassertion: synchronous use on the first CLK edge after release.
- START sampled at cycle 0: RUN from cycle 1 with pre=0; ticks at cycles k·PRESCALE, k≥1.
- One-shot: terminal tick at cycle (term_q+1)·PRESCALE; DONE high only at cycle (term_q+1)·PRESCALE+1; STATE=FIN from the same cycle.
- Auto-reload: terminal events every (term_q+1)·PRESCALE cycles; DONE is a single-cycle pulse each time.
- CNT_EN/CNT_RESN change combinationally with state/pre/commands. They are never both active: clear wins and CNT_EN is forced 0.
- RES mid-sequence: immediate IDLE, with all outputs at their reset values within the same cycle.

## Test plan
- PRESCALE=4, TERM=3, MODE=0, START pulse at cycle 0 -> CNT_EN high at cycles 4, 8, 12 (count 1, 2, 3). Cycle 16 is the terminal cycle with CNT_EN=0. DONE high only at cycle 17; STATE=3; CNT_VAL holds 3.
- PRESCALE=1, TERM=2, MODE=1, START held -> counter sequence 0, 1, 2, 0, 1, 2…. DONE pulses every 3 cycles. WRAPS increments each pulse and saturates at 255 after 255 events.
- PRESCALE=4, TERM=5, STOP at cycle 6 for 10 cycles, then START -> count frozen at 1 and pre frozen at 1 in PAUSE. After resume, the next CNT_EN comes exactly 3 cycles later. DONE arrives 11 cycles later than the unpaused run.
- CLEAR and START asserted together while RUN -> CNT_RESN=0 that cycle; STATE=0 next cycle; WRAPS=0; no DONE.
- TERM=0, PRESCALE=2, MODE=0 -> DONE at cycle 3; CNT_EN never asserted; CNT_VAL stays 0.
- RES asserted asynchronously mid-RUN (PRESCALE=4, TERM=9) -> outputs at reset values before the next edge. After release, START restarts from count 0 with the full period.
